// File: rtl/board_test_pkg.sv
// Shared types for the SDRAM board-test front end: request FSM states,
// click FSM states and the click-kind encoding used by the click decoder.
package board_test_pkg;

  // Host request sequencer states.
  typedef enum logic [1:0] {
    RS_IDLE        = 2'd0,
    RS_WAIT_ACCEPT = 2'd1,
    RS_WAIT_DONE   = 2'd2
  } req_state_t;

  // Button click sequence states.
  typedef enum logic [1:0] {
    CS_IDLE     = 2'd0,
    CS_PRESSED  = 2'd1,
    CS_RELEASED = 2'd2
  } click_state_t;

  // Number of clicks seen in the current sequence (value equals the count).
  typedef enum logic [1:0] {
    CLICK_NONE   = 2'd0,
    CLICK_SINGLE = 2'd1,
    CLICK_DOUBLE = 2'd2,
    CLICK_TRIPLE = 2'd3
  } click_kind_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_test_interface_if.sv
// Host port between the board-test front end and the SDRAM controller,
// plus debug visibility of both front-end state machines.
//
// Handshake: the master raises exactly one of wr_enable/rd_enable and holds
// it, with haddr/data_input stable, until it samples busy=1 on a clk edge;
// it then drops the enable. The transaction is complete on the first later
// edge where busy=0; read data on data_output is taken on that edge.
interface board_test_interface_if #(
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16
);
  import board_test_pkg::*;

  logic [HADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0]  data_input;
  logic [DATA_WIDTH-1:0]  data_output;
  logic                   busy;
  logic                   rd_enable;
  logic                   wr_enable;

  // Debug view of the front-end state machines.
  req_state_t             req_state;
  click_state_t           click_state;

  modport master (
    output haddr, data_input, rd_enable, wr_enable, req_state, click_state,
    input  data_output, busy
  );

  modport slave (
    input  haddr, data_input, rd_enable, wr_enable, req_state, click_state,
    output data_output, busy
  );

endinterface

// File: rtl/board_test_interface_click_decoder.sv
// Button synchroniser, debouncer and click-sequence decoder. Emits a
// one-cycle pulse on click_single/click_double/click_triple once the click
// window after the last release expires.
// Optional: BOARD_TEST_TRIPLE_CLICK_EN lets the count reach three; without it
// the count saturates at two so longer sequences decode as double.
module click_decoder
  import board_test_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CLICK_WINDOW    = 8388608
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         button,
  output logic         click_single,
  output logic         click_double,
  output logic         click_triple,
  output click_state_t state
);

  localparam int DBW = cnt_w(DEBOUNCE_CYCLES);
  localparam int WW  = cnt_w(CLICK_WINDOW);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0]  WIN_LAST = WW'(CLICK_WINDOW - 1);

`ifdef BOARD_TEST_TRIPLE_CLICK_EN
  localparam click_kind_t CLICK_MAX = CLICK_TRIPLE;
`else
  localparam click_kind_t CLICK_MAX = CLICK_DOUBLE;
`endif

  logic [1:0]     sync_q, sync_d;
  logic           level_q, level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           rise, fall;

  click_kind_t    count_q;
  logic [WW-1:0]  win_q;

  // Synchroniser shift and debounce: accept a new level only after the
  // synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles.
  always_comb begin
    sync_d   = {sync_q[0], button};
    level_d  = level_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync_q[1];
        rise    = sync_q[1];
        fall    = ~sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debouncer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Click FSM: count presses separated by less than the window, report the
  // total once the window after the final release runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CS_IDLE;
      count_q      <= CLICK_NONE;
      win_q        <= '0;
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
    end else begin
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      case (state)
        CS_IDLE: begin
          if (rise) begin
            state   <= CS_PRESSED;
            count_q <= CLICK_SINGLE;
          end
        end
        CS_PRESSED: begin
          if (fall) begin
            state <= CS_RELEASED;
            win_q <= '0;
          end
        end
        CS_RELEASED: begin
          if (rise) begin
            state <= CS_PRESSED;
            if (count_q != CLICK_MAX) count_q <= click_kind_t'(count_q + 2'd1);
          end else if (win_q == WIN_LAST) begin
            state        <= CS_IDLE;
            click_single <= (count_q == CLICK_SINGLE);
            click_double <= (count_q == CLICK_DOUBLE);
            click_triple <= (count_q == CLICK_TRIPLE);
          end else begin
            win_q <= win_q + 1'b1;
          end
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_test_interface.sv
// Push-button front end for bench-testing the SDRAM controller: single
// click writes the DIP pattern to the next slot, double click reads back
// the last written slot, read data is scanned onto the LEDs slice by slice.
// Optional: BOARD_TEST_TRIPLE_CLICK_EN makes a triple click clear the
// address and captured data without a controller request.
module board_test_interface
  import board_test_pkg::*;
#(
  parameter int HADDR_WIDTH      = 24,
  parameter int DATA_WIDTH       = 16,
  parameter int DIP_WIDTH        = 4,
  parameter int LED_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES  = 65536,
  parameter int CLICK_WINDOW     = 8388608,
  parameter int LED_SLICE_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button,
  input  logic [DIP_WIDTH-1:0] dip,
  output logic [LED_WIDTH-1:0] leds,
  board_test_interface_if.master host
);

  localparam int NSLICE = DATA_WIDTH / LED_WIDTH;
  localparam int IW     = cnt_w(NSLICE);
  localparam int TW     = cnt_w(LED_SLICE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(LED_SLICE_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NSLICE - 1);

  logic         click_single, click_double, click_triple, read_click;
  click_state_t click_state;

  req_state_t             req_q;
  logic                   is_read_q;
  logic                   wr_en_q, rd_en_q;
  logic [HADDR_WIDTH-1:0] wr_ptr_q;   // next write slot
  logic [HADDR_WIDTH-1:0] haddr_q;    // address presented to the controller
  logic [DATA_WIDTH-1:0]  capt_q;

  logic [TW-1:0]        slice_tmr_q, slice_tmr_d;
  logic [IW-1:0]        slice_idx_q, slice_idx_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;

  click_decoder #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CLICK_WINDOW    (CLICK_WINDOW)
  ) u_click (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .click_single (click_single),
    .click_double (click_double),
    .click_triple (click_triple),
    .state        (click_state)
  );

`ifdef BOARD_TEST_TRIPLE_CLICK_EN
  assign read_click = click_double;
`else
  // Triple never fires in this build; folding it in keeps 3+ clicks a read.
  assign read_click = click_double | click_triple;
`endif

  // Request FSM: one controller transaction per accepted click, pulses
  // arriving while a transaction is open are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= RS_IDLE;
      is_read_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_ptr_q  <= '0;
      haddr_q   <= '0;
      capt_q    <= '0;
    end else begin
      case (req_q)
        RS_IDLE: begin
          if (click_single) begin
            wr_en_q   <= 1'b1;
            is_read_q <= 1'b0;
            req_q     <= RS_WAIT_ACCEPT;
          end else if (read_click) begin
            // Read back the most recently written slot.
            rd_en_q   <= 1'b1;
            is_read_q <= 1'b1;
            haddr_q   <= wr_ptr_q - 1'b1;
            req_q     <= RS_WAIT_ACCEPT;
          end
`ifdef BOARD_TEST_TRIPLE_CLICK_EN
          else if (click_triple) begin
            wr_ptr_q <= '0;
            haddr_q  <= '0;
            capt_q   <= '0;
          end
`endif
        end
        RS_WAIT_ACCEPT: begin
          if (host.busy) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            req_q   <= RS_WAIT_DONE;
          end
        end
        RS_WAIT_DONE: begin
          if (!host.busy) begin
            req_q <= RS_IDLE;
            if (is_read_q) begin
              capt_q  <= host.data_output;
              haddr_q <= wr_ptr_q;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              haddr_q  <= wr_ptr_q + 1'b1;
            end
          end
        end
        default: req_q <= RS_IDLE;
      endcase
    end
  end

  // LED scan: advance the displayed slice every LED_SLICE_CYCLES cycles.
  always_comb begin
    slice_tmr_d = slice_tmr_q + 1'b1;
    slice_idx_d = slice_idx_q;
    if (slice_tmr_q == T_LAST) begin
      slice_tmr_d = '0;
      slice_idx_d = (slice_idx_q == I_LAST) ? '0 : slice_idx_q + 1'b1;
    end
    leds_d = capt_q[slice_idx_q*LED_WIDTH +: LED_WIDTH];
  end

  // LED scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_tmr_q <= '0;
      slice_idx_q <= '0;
      leds_q      <= '0;
    end else begin
      slice_tmr_q <= slice_tmr_d;
      slice_idx_q <= slice_idx_d;
      leds_q      <= leds_d;
    end
  end

  // Write data: DIP pattern replicated, every odd copy inverted.
  always_comb begin
    host.data_input = '0;
    for (int i = 0; i < DATA_WIDTH / DIP_WIDTH; i++) begin
      host.data_input[i*DIP_WIDTH +: DIP_WIDTH] = (i % 2 == 1) ? ~dip : dip;
    end
  end

  assign leds             = leds_q;
  assign host.haddr       = haddr_q;
  assign host.wr_enable   = wr_en_q;
  assign host.rd_enable   = rd_en_q;
  assign host.req_state   = req_q;
  assign host.click_state = click_state;

endmodule
